// File: rtl/agc_time_pulse_gen.sv
`timescale 1ns/1ps
// Purpose: AGC master timing sequencer producing T01..T12, phase strobes, Johnson phase counter, stop/step control.
// Latency: every output is a flop; an input sampled at one rising edge shows up on outputs right after that edge.
// Backpressure: none; GOJAM/STOP_/MSTRT are sampled every clock, downstream must consume pulses as they occur.
module agc_time_pulse_gen #(
  parameter int PHASES_PER_T = 4,
  parameter int TPULSES      = 12
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic GOJAM,
  input  logic STOP_,
  input  logic MSTRT,
  output logic T01,
  output logic T02,
  output logic T03,
  output logic T04,
  output logic T05,
  output logic T06,
  output logic T07,
  output logic T08,
  output logic T09,
  output logic T10,
  output logic T11,
  output logic T12,
  output logic T01_,
  output logic T02_,
  output logic T03_,
  output logic T04_,
  output logic T05_,
  output logic T06_,
  output logic T07_,
  output logic T08_,
  output logic T09_,
  output logic T10_,
  output logic T11_,
  output logic T12_,
  output logic P01,
  output logic P02,
  output logic P03,
  output logic P04,
  output logic P05,
  output logic P05_,
  output logic PHS2_,
  output logic PHS4_,
  output logic T12USE_,
  output logic STOPPED
);

  // The phase/pulse counters below are sized for exactly 4 phases and 12 pulses.
  if (PHASES_PER_T != 4 || TPULSES != 12) begin : g_cfg_check
    $error("agc_time_pulse_gen: PHASES_PER_T must be 4 and TPULSES must be 12");
  end

  localparam logic [1:0] PH_LAST = 2'd3;
  localparam logic [3:0] TP_FIRST = 4'd1;
  localparam logic [3:0] TP_LAST  = 4'd12;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_STOP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [3:0]  tp_q, tp_d;
  logic [4:0]  jc_q, jc_d;

  logic        run_d;
  logic [12:1] t_d;
  logic        phs2_n_d, phs4_n_d, t12use_n_d;

  logic [12:1] t_q, t_n_q;
  logic        p05_n_q, phs2_n_q, phs4_n_q, t12use_n_q, stopped_q;

  // Next-state: GOJAM restart, then stop/step handling, then normal phase/pulse advance
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    tp_d    = tp_q;
    jc_d    = jc_q;
    if (GOJAM) begin
      // Restart truncates the MCT without a stop check; jc deliberately untouched.
      state_d = S_RUN;
      ph_d    = 2'd0;
      tp_d    = TP_FIRST;
    end else if (state_q == S_STOP) begin
      // STOP_ released or a single-step request both resume at T01 ph0.
      // A step with STOP_ still low stops again at the next end of MCT.
      if (STOP_ || MSTRT) begin
        state_d = S_RUN;
        ph_d    = 2'd0;
        tp_d    = TP_FIRST;
      end
    end else if (ph_q == PH_LAST) begin
      ph_d = 2'd0;
      if (tp_q == TP_LAST) begin
        // End of MCT: Johnson counter steps whether or not we stop here.
        jc_d = {jc_q[3:0], ~jc_q[4]};
        tp_d = TP_FIRST;
        if (!STOP_) begin
          state_d = S_STOP;
        end
      end else begin
        tp_d = tp_q + 4'd1;
      end
    end else begin
      ph_d = ph_q + 2'd1;
    end
  end

  // Output decode of the next state, so the output flops hold the decode of the current state
  always_comb begin
    run_d      = (state_d == S_RUN);
    t_d        = '0;
    if (run_d) begin
      t_d = 12'h001 << (tp_d - TP_FIRST);
    end
    phs2_n_d   = !(run_d && (ph_d == 2'd1));
    phs4_n_d   = !(run_d && (ph_d == 2'd3));
    // STOP_ is registered here as part of the output decode, giving the per-clock re-evaluation.
    t12use_n_d = !(run_d && (tp_d == TP_LAST) && STOP_);
  end

  // Sequencer state registers
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q <= S_RUN;
      ph_q    <= 2'd0;
      tp_q    <= TP_FIRST;
      jc_q    <= 5'b00000;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      tp_q    <= tp_d;
      jc_q    <= jc_d;
    end
  end

  // Output registers, reset to the T01 ph0 running decode
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      t_q        <= 12'h001;
      t_n_q      <= ~12'h001;
      p05_n_q    <= 1'b1;
      phs2_n_q   <= 1'b1;
      phs4_n_q   <= 1'b1;
      t12use_n_q <= 1'b1;
      stopped_q  <= 1'b0;
    end else begin
      t_q        <= t_d;
      t_n_q      <= ~t_d;
      p05_n_q    <= ~jc_d[4];
      phs2_n_q   <= phs2_n_d;
      phs4_n_q   <= phs4_n_d;
      t12use_n_q <= t12use_n_d;
      stopped_q  <= ~run_d;
    end
  end

  assign T01  = t_q[1];
  assign T02  = t_q[2];
  assign T03  = t_q[3];
  assign T04  = t_q[4];
  assign T05  = t_q[5];
  assign T06  = t_q[6];
  assign T07  = t_q[7];
  assign T08  = t_q[8];
  assign T09  = t_q[9];
  assign T10  = t_q[10];
  assign T11  = t_q[11];
  assign T12  = t_q[12];
  assign T01_ = t_n_q[1];
  assign T02_ = t_n_q[2];
  assign T03_ = t_n_q[3];
  assign T04_ = t_n_q[4];
  assign T05_ = t_n_q[5];
  assign T06_ = t_n_q[6];
  assign T07_ = t_n_q[7];
  assign T08_ = t_n_q[8];
  assign T09_ = t_n_q[9];
  assign T10_ = t_n_q[10];
  assign T11_ = t_n_q[11];
  assign T12_ = t_n_q[12];

  assign P01     = jc_q[0];
  assign P02     = jc_q[1];
  assign P03     = jc_q[2];
  assign P04     = jc_q[3];
  assign P05     = jc_q[4];
  assign P05_    = p05_n_q;
  assign PHS2_   = phs2_n_q;
  assign PHS4_   = phs4_n_q;
  assign T12USE_ = t12use_n_q;
  assign STOPPED = stopped_q;

endmodule

// File: tb/tb_agc_time_pulse_gen.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for agc_time_pulse_gen (table vectors, directed corners, random vs. reference model).
// Latency: inputs driven 2ns after a rising edge, outputs compared 2ns after the following rising edge.
// Backpressure: not applicable.
module tb_agc_time_pulse_gen;

  logic CLOCK, rst, GOJAM, STOP_, MSTRT;
  logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
  logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
  logic P01, P02, P03, P04, P05, P05_, PHS2_, PHS4_, T12USE_, STOPPED;

  agc_time_pulse_gen dut (
    .CLOCK(CLOCK), .rst(rst), .GOJAM(GOJAM), .STOP_(STOP_), .MSTRT(MSTRT),
    .T01(T01), .T02(T02), .T03(T03), .T04(T04), .T05(T05), .T06(T06),
    .T07(T07), .T08(T08), .T09(T09), .T10(T10), .T11(T11), .T12(T12),
    .T01_(T01_), .T02_(T02_), .T03_(T03_), .T04_(T04_), .T05_(T05_), .T06_(T06_),
    .T07_(T07_), .T08_(T08_), .T09_(T09_), .T10_(T10_), .T11_(T11_), .T12_(T12_),
    .P01(P01), .P02(P02), .P03(P03), .P04(P04), .P05(P05), .P05_(P05_),
    .PHS2_(PHS2_), .PHS4_(PHS4_), .T12USE_(T12USE_), .STOPPED(STOPPED)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // {T12..T01, T12_..T01_, P05..P01, P05_, PHS2_, PHS4_, T12USE_, STOPPED}
  logic [33:0] dut_vec;
  assign dut_vec = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01,
                    T12_, T11_, T10_, T09_, T08_, T07_, T06_, T05_, T04_, T03_, T02_, T01_,
                    P05, P04, P03, P02, P01, P05_, PHS2_, PHS4_, T12USE_, STOPPED};

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  // Reference model: position 0..47 inside the MCT, stopped flag, Johnson step index.
  int m_pos;
  bit m_stopped;
  int m_jidx;
  bit m_stopq;

  function automatic logic [4:0] jc_of(input int idx);
    case (idx % 10)
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00011;
      3: return 5'b00111;
      4: return 5'b01111;
      5: return 5'b11111;
      6: return 5'b11110;
      7: return 5'b11100;
      8: return 5'b11000;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [33:0] pack_vec(input logic [12:1] t, input logic [4:0] p,
                                           input logic phs2n, input logic phs4n,
                                           input logic t12n, input logic stp);
    return {t, ~t, p, ~p[4], phs2n, phs4n, t12n, stp};
  endfunction

  function automatic logic [33:0] model_vec();
    logic [12:1] t;
    t = '0;
    if (!m_stopped) t[m_pos / 4 + 1] = 1'b1;
    return pack_vec(t, jc_of(m_jidx),
                    !(!m_stopped && (m_pos % 4 == 1)),
                    !(!m_stopped && (m_pos % 4 == 3)),
                    !(!m_stopped && (m_pos >= 44) && m_stopq),
                    m_stopped);
  endfunction

  task automatic model_step(input logic r, input logic g, input logic s, input logic m);
    if (r) begin
      m_pos = 0; m_stopped = 0; m_jidx = 0; m_stopq = 1;
    end else begin
      if (g) begin
        m_pos = 0; m_stopped = 0;
      end else if (m_stopped) begin
        if (s || m) begin m_stopped = 0; m_pos = 0; end
      end else if (m_pos == 47) begin
        m_jidx = (m_jidx + 1) % 10;
        m_pos = 0;
        if (!s) m_stopped = 1;
      end else begin
        m_pos++;
      end
      m_stopq = s;
    end
  endtask

  task automatic cyc(input logic r, input logic g, input logic s, input logic m);
    rst = r; GOJAM = g; STOP_ = s; MSTRT = m;
    @(posedge CLOCK);
    model_step(r, g, s, m);
    cyc_no++;
    #2;
  endtask

  task automatic check_model(input string name);
    logic [33:0] e;
    e = model_vec();
    vectors++;
    if (dut_vec !== e) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc_no, dut_vec, e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_no, got, exp);
    end
  endtask

  typedef struct {
    logic r, g, s, m;
    logic [12:1] t;
    logic phs2n, phs4n, t12n, stp;
    logic [4:0] p;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic r, input logic g, input logic s, input logic m,
                              input logic [12:1] t, input logic phs2n, input logic phs4n,
                              input logic t12n, input logic stp, input logic [4:0] p);
    vec_t v;
    v.r = r; v.g = g; v.s = s; v.m = m; v.t = t;
    v.phs2n = phs2n; v.phs4n = phs4n; v.t12n = t12n; v.stp = stp; v.p = p;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_cnt;
    bit s_state;
    logic [33:0] rst_exp;
    rst = 1'b1; GOJAM = 1'b0; STOP_ = 1'b1; MSTRT = 1'b0;
    m_pos = 0; m_stopped = 0; m_jidx = 0; m_stopq = 1;

    //               r  g  s  m  T         PHS2_ PHS4_ T12USE_ STOPPED P
    tbl[0] = mk(1, 0, 1, 0, 12'h001, 1, 1, 1, 0, 5'b0);  // reset values
    tbl[1] = mk(1, 1, 1, 0, 12'h001, 1, 1, 1, 0, 5'b0);  // rst beats GOJAM
    tbl[2] = mk(0, 0, 1, 0, 12'h001, 0, 1, 1, 0, 5'b0);  // T01 ph1
    tbl[3] = mk(0, 0, 1, 0, 12'h001, 1, 1, 1, 0, 5'b0);  // T01 ph2
    tbl[4] = mk(0, 0, 1, 0, 12'h001, 1, 0, 1, 0, 5'b0);  // T01 ph3
    tbl[5] = mk(0, 0, 1, 0, 12'h002, 1, 1, 1, 0, 5'b0);  // T02 ph0
    tbl[6] = mk(0, 1, 1, 0, 12'h001, 1, 1, 1, 0, 5'b0);  // GOJAM -> T01 ph0
    tbl[7] = mk(0, 1, 1, 1, 12'h001, 1, 1, 1, 0, 5'b0);  // GOJAM+MSTRT pinned
    tbl[8] = mk(0, 0, 1, 0, 12'h001, 0, 1, 1, 0, 5'b0);  // T01 ph1
    tbl[9] = mk(1, 0, 1, 0, 12'h001, 1, 1, 1, 0, 5'b0);  // back to reset
    rst_exp = pack_vec(12'h001, 5'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [33:0] e;
      cyc(tbl[i].r, tbl[i].g, tbl[i].s, tbl[i].m);
      e = pack_vec(tbl[i].t, tbl[i].p, tbl[i].phs2n, tbl[i].phs4n, tbl[i].t12n, tbl[i].stp);
      vectors++;
      if (dut_vec !== e) begin
        miscompares++;
        $display("FAIL table[%0d] got=%h exp=%h", i, dut_vec, e);
      end
    end

    // Free run from reset: call k leaves the DUT at clock k+1.
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 1, 0);
      check_model("free_run");
      if (k == 0)  chk("phs2_clk1", {31'd0, PHS2_}, 32'd0);
      if (k == 4)  chk("phs2_clk5", {31'd0, PHS2_}, 32'd0);
      if (k == 43) chk("t12use_clk44", {30'd0, T12, T12USE_}, 32'b10);
      if (k == 47) chk("t12use_clk48", {30'd0, T01, T12USE_}, 32'b11);
    end

    // Johnson counter across 10 MCTs.
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 480; k++) begin
      cyc(0, 0, 1, 0);
      check_model("johnson");
      if ((k + 1) % 48 == 0)
        chk("jc_step", {27'd0, P05, P04, P03, P02, P01}, {27'd0, jc_of((k + 1) / 48)});
    end
    chk("jc_wrap", {27'd0, P05, P04, P03, P02, P01}, 32'd0);

    // Stop at clock 30, resume at clock 60.
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 70; k++) begin
      cyc(0, 0, (k < 30 || k >= 60), 0);
      check_model("stop");
      if (k == 43) chk("stop_t12use_clk44", {30'd0, T12, T12USE_}, 32'b11);
      if (k == 47) chk("stopped_clk48", {30'd0, STOPPED, T01}, 32'b10);
      if (k == 60) chk("resume_clk61", {30'd0, STOPPED, T01}, 32'b01);
    end

    // Single step: stop after first MCT, then one MSTRT pulse.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 48; k++) begin
      cyc(0, 0, 0, 0);
      check_model("step_prep");
    end
    chk("step_stopped_jc", {26'd0, STOPPED, P05, P04, P03, P02, P01}, {26'd0, 1'b1, 5'b00001});
    cyc(0, 0, 0, 0);
    check_model("step_idle");
    cyc(0, 0, 0, 1);
    check_model("step_pulse");
    run_cnt = 0;
    for (int k = 0; k < 60 && !STOPPED; k++) begin
      run_cnt++;
      cyc(0, 0, 0, 0);
      check_model("step_run");
    end
    chk("step_len", run_cnt, 48);
    chk("step_end_jc", {26'd0, STOPPED, P05, P04, P03, P02, P01}, {26'd0, 1'b1, 5'b00011});

    // GOJAM while stopped, then GOJAM at T07 ph2.
    cyc(0, 1, 0, 0);
    chk("gojam_unstop", {30'd0, STOPPED, T01}, 32'b01);
    check_model("gojam_unstop");
    for (int k = 0; k < 26; k++) begin
      cyc(0, 0, 1, 0);
      check_model("to_t07");
    end
    chk("at_t07_ph2", {29'd0, T07, PHS2_, PHS4_}, 32'b111);
    cyc(0, 1, 1, 0);
    chk("gojam_t07", {25'd0, T01, T07, PHS2_, PHS4_, P03, P02, P01}, {25'd0, 7'b1011011});
    check_model("gojam_t07");

    // rst during T09 with GOJAM held high.
    for (int k = 0; k < 33; k++) begin
      cyc(0, 0, 1, 0);
      check_model("to_t09");
    end
    chk("at_t09", {31'd0, T09}, 32'd1);
    cyc(1, 1, 1, 0);
    vectors++;
    if (dut_vec !== rst_exp) begin
      miscompares++;
      $display("FAIL rst_mid_t09 got=%h exp=%h", dut_vec, rst_exp);
    end

    // Randomized run against the reference model.
    s_state = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) s_state = ~s_state;
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 149) == 0), s_state,
          ($urandom_range(0, 29) == 0));
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
